// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: sequencer states and read-owner tags shared by the arbiter
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {ST_BOOT, ST_DRAIN, ST_RUN} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_DATA} owner_t;
endpackage

// File: rtl/mem_port_arbiter_streak.sv
// mem_port_arbiter_streak: data-priority arbitration with a saturating streak that forces fetch through
module mem_port_arbiter_streak #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    input  logic fetch_req,
    input  logic data_req,
    output logic fetch_gnt,
    output logic data_gnt
);
    localparam logic [3:0] MAX = 4'(MAX_DATA_STREAK);
    logic [3:0] streak_q, streak_d;
    always_comb begin
        fetch_gnt = run && fetch_req && (!data_req || streak_q == MAX);
        data_gnt  = run && data_req && !fetch_gnt;
        streak_d  = (!fetch_req || fetch_gnt) ? 4'd0 :
                    (data_gnt && streak_q != MAX) ? streak_q + 4'd1 : streak_q;
    end
    always_ff @(posedge clock) begin
        if (!reset_n) streak_q <= 4'd0;
        else          streak_q <= streak_d;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: boot-then-run sequencer sharing one memory port between loader, fetch and data stage
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  boot_req,
    input  logic                  boot_wren,
    input  logic [ADDR_WIDTH-1:0] boot_address,
    input  logic [DATA_WIDTH-1:0] boot_data_in,
    input  logic                  boot_done,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_address,
    output logic                  fetch_gnt,
    output logic                  fetch_rvalid,
    output logic [DATA_WIDTH-1:0] fetch_data,
    input  logic                  data_req,
    input  logic                  data_wren,
    input  logic [ADDR_WIDTH-1:0] data_address,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic                  data_gnt,
    output logic                  data_rvalid,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  fetch_stall,
    output logic                  busy
);
    state_t state_q, state_d;
    owner_t owner_q, owner_d;

    mem_port_arbiter_streak #(.MAX_DATA_STREAK(MAX_DATA_STREAK)) u_streak (
        .clock     (clock),
        .reset_n   (reset_n),
        .run       (state_q == ST_RUN),
        .fetch_req (fetch_req),
        .data_req  (data_req),
        .fetch_gnt (fetch_gnt),
        .data_gnt  (data_gnt)
    );

    always_comb begin
        state_d     = (state_q == ST_BOOT) ? (boot_done ? ST_DRAIN : ST_BOOT) : ST_RUN;
        owner_d     = fetch_gnt ? OWN_FETCH : (data_gnt && !data_wren) ? OWN_DATA : OWN_NONE;
        mem_address = '0;
        mem_wren    = 1'b0;
        mem_data_in = '0;
        if (state_q == ST_BOOT && boot_req) begin
            mem_address = boot_address;
            mem_wren    = boot_wren;
            mem_data_in = boot_data_in;
        end else if (fetch_gnt) begin
            mem_address = fetch_address;
        end else if (data_gnt) begin
            mem_address = data_address;
            mem_wren    = data_wren;
            mem_data_in = data_wren ? data_wdata : '0;
        end
    end

    // read data returns one cycle after its grant, steered by the registered owner
    assign fetch_rvalid = owner_q == OWN_FETCH;
    assign data_rvalid  = owner_q == OWN_DATA;
    assign fetch_data   = fetch_rvalid ? mem_data_out : '0;
    assign data_rdata   = data_rvalid ? mem_data_out : '0;
    assign fetch_stall  = fetch_req && !fetch_gnt;
    assign busy         = state_q != ST_RUN;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_BOOT;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus randomized traffic against a behavioural model
module tb_mem_port_arbiter;
    localparam int MAX = 4;
    localparam logic [31:0] A0 = 32'h8002_0000, A4 = 32'h8002_0004, A100 = 32'h8002_0100;

    logic clock = 1'b0, reset_n;
    logic boot_req, boot_wren, boot_done;
    logic [31:0] boot_address, boot_data_in;
    logic fetch_req, fetch_gnt, fetch_rvalid;
    logic [31:0] fetch_address, fetch_data;
    logic data_req, data_wren, data_gnt, data_rvalid;
    logic [31:0] data_address, data_wdata, data_rdata;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic mem_wren, fetch_stall, busy;

    mem_port_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .boot_req(boot_req), .boot_wren(boot_wren), .boot_address(boot_address),
        .boot_data_in(boot_data_in), .boot_done(boot_done),
        .fetch_req(fetch_req), .fetch_address(fetch_address), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_data(fetch_data),
        .data_req(data_req), .data_wren(data_wren), .data_address(data_address),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata), .mem_address(mem_address), .mem_wren(mem_wren),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .fetch_stall(fetch_stall), .busy(busy)
    );

    always #5 clock = ~clock;

    int errors = 0, checks = 0;
    logic [31:0] mem [logic [31:0]];

    // model: phase 0 loading, 1 settling, 2 running; own 0 none, 1 fetch, 2 data
    int phase = 0, data_wins = 0, own = 0;
    logic [31:0] own_val = '0;
    bit s_fg, s_dg;
    logic [31:0] s_ea, act_a, act_d;
    bit act_w;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic settle();
        bit efg, edg, ewr, drv;
        logic [31:0] ea, ed;
        #3;
        efg = phase == 2 && fetch_req && (!data_req || data_wins == MAX);
        edg = phase == 2 && data_req && !efg;
        drv = (phase == 0 && boot_req) || efg || edg;
        ea = '0; ewr = 1'b0; ed = '0;
        if (phase == 0 && boot_req) begin
            ea = boot_address; ewr = boot_wren; ed = boot_data_in;
        end else if (efg) ea = fetch_address;
        else if (edg) begin
            ea = data_address; ewr = data_wren; ed = data_wren ? data_wdata : 32'h0;
        end
        chk("fetch_gnt", fetch_gnt, efg);
        chk("data_gnt", data_gnt, edg);
        chk("mem_wren", mem_wren, ewr);
        chk("mem_address", mem_address, ea);
        if (ewr || !drv) chk("mem_data_in", mem_data_in, ed);
        chk("fetch_stall", fetch_stall, fetch_req && !efg);
        chk("busy", busy, phase != 2);
        chk("fetch_rvalid", fetch_rvalid, own == 1);
        chk("fetch_data", fetch_data, own == 1 ? own_val : 32'h0);
        chk("data_rvalid", data_rvalid, own == 2);
        chk("data_rdata", data_rdata, own == 2 ? own_val : 32'h0);
        s_fg = efg; s_dg = edg; s_ea = ea;
        act_a = mem_address; act_w = mem_wren; act_d = mem_data_in;
    endtask

    task automatic advance();
        logic [31:0] nv;
        @(posedge clock);
        nv = rd(s_ea);
        mem_data_out = rd(act_a);
        if (act_w) mem[act_a] = act_d;
        if (!reset_n) begin
            phase = 0; data_wins = 0; own = 0;
        end else begin
            if (!fetch_req || s_fg) data_wins = 0;
            else if (s_dg && data_wins < MAX) data_wins++;
            own = s_fg ? 1 : (s_dg && !data_wren) ? 2 : 0;
            own_val = nv;
            if (phase == 0 && boot_done) phase = 1;
            else if (phase == 1) phase = 2;
        end
        #1;
    endtask

    typedef struct {
        bit rst_n, breq, bwr, bdone, freq, dreq, dwr;
        logic [31:0] baddr, bdata, faddr, daddr, wdata;
        bit fg, dg, wr;
        logic [31:0] maddr;
        bit frv, drv;
        logic [31:0] rdv;
        bit bsy;
    } vec_t;

    function automatic vec_t mk(input bit rst_n, breq, bwr, bdone, freq, dreq, dwr,
                                input logic [31:0] baddr, bdata, faddr, daddr, wdata,
                                input bit fg, dg, wr, input logic [31:0] maddr,
                                input bit frv, drv, input logic [31:0] rdv, input bit bsy);
        vec_t v;
        v.rst_n = rst_n; v.breq = breq; v.bwr = bwr; v.bdone = bdone;
        v.freq = freq; v.dreq = dreq; v.dwr = dwr;
        v.baddr = baddr; v.bdata = bdata; v.faddr = faddr; v.daddr = daddr; v.wdata = wdata;
        v.fg = fg; v.dg = dg; v.wr = wr; v.maddr = maddr;
        v.frv = frv; v.drv = drv; v.rdv = rdv; v.bsy = bsy;
        return v;
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h8000_0000 | (32'($urandom_range(0, 7)) << 2);
    endfunction

    vec_t v [21];

    initial begin
        reset_n = 1'b0; boot_req = 0; boot_wren = 0; boot_done = 0;
        boot_address = '0; boot_data_in = '0; fetch_req = 0; fetch_address = '0;
        data_req = 0; data_wren = 0; data_address = '0; data_wdata = '0; mem_data_out = '0;
        @(posedge clock); #1;
        fetch_req = 1; data_req = 1; data_wren = 1;
        repeat (2) begin settle(); advance(); end

        v[0] = mk(1,1,1,0,1,0,0, A0,32'hDEADBEEF,A0,0,0, 0,0,1,A0, 0,0,0,1);
        v[1] = mk(1,1,1,1,1,0,0, A4,32'hCAFEF00D,A0,0,0, 0,0,1,A4, 0,0,0,1);
        v[2] = mk(1,0,0,1,1,0,0, 0,0,A0,0,0, 0,0,0,0, 0,0,0,1);
        v[3] = mk(1,0,0,1,1,0,0, 0,0,A0,0,0, 1,0,0,A0, 0,0,0,0);
        v[4] = mk(1,0,0,1,0,0,0, 0,0,0,0,0, 0,0,0,0, 1,0,32'hDEADBEEF,0);
        for (int k = 0; k < 10; k++) begin
            bit f, pf;
            f = (k % 5) == 4;
            pf = k > 0 && ((k - 1) % 5) == 4;
            v[5+k] = mk(1,0,0,1,1,1,0, 0,0,A4,A0,0, f,!f,0, f ? A4 : A0,
                        pf, k > 0 && !pf, k == 0 ? 32'h0 : pf ? 32'hCAFEF00D : 32'hDEADBEEF, 0);
        end
        v[15] = mk(1,0,0,1,1,1,1, 0,0,A4,A100,32'h12345678, 0,1,1,A100, 1,0,32'hCAFEF00D,0);
        v[16] = mk(1,0,0,1,1,1,0, 0,0,A4,A100,0, 0,1,0,A100, 0,0,0,0);
        v[17] = mk(1,0,0,1,1,0,0, 0,0,A4,0,0, 1,0,0,A4, 0,1,32'h12345678,0);
        v[18] = mk(0,0,0,1,0,1,0, 0,0,0,A0,0, 0,1,0,A0, 1,0,32'hCAFEF00D,0);
        v[19] = mk(1,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0, 0,0,0,1);
        v[20] = mk(1,0,0,0,1,0,0, 0,0,A0,0,0, 0,0,0,0, 0,0,0,1);

        for (int i = 0; i < 21; i++) begin
            reset_n = v[i].rst_n; boot_req = v[i].breq; boot_wren = v[i].bwr;
            boot_done = v[i].bdone; boot_address = v[i].baddr; boot_data_in = v[i].bdata;
            fetch_req = v[i].freq; fetch_address = v[i].faddr;
            data_req = v[i].dreq; data_wren = v[i].dwr; data_address = v[i].daddr;
            data_wdata = v[i].wdata;
            settle();
            chk($sformatf("vec%0d fetch_gnt", i), fetch_gnt, v[i].fg);
            chk($sformatf("vec%0d data_gnt", i), data_gnt, v[i].dg);
            chk($sformatf("vec%0d mem_wren", i), mem_wren, v[i].wr);
            chk($sformatf("vec%0d mem_address", i), mem_address, v[i].maddr);
            chk($sformatf("vec%0d fetch_rvalid", i), fetch_rvalid, v[i].frv);
            chk($sformatf("vec%0d data_rvalid", i), data_rvalid, v[i].drv);
            if (v[i].frv) chk($sformatf("vec%0d fetch_data", i), fetch_data, v[i].rdv);
            if (v[i].drv) chk($sformatf("vec%0d data_rdata", i), data_rdata, v[i].rdv);
            chk($sformatf("vec%0d busy", i), busy, v[i].bsy);
            advance();
        end

        reset_n = 0; fetch_req = 0; data_req = 0; boot_req = 0; boot_done = 0;
        settle(); advance();
        reset_n = 1;
        for (int i = 0; i < 800; i++) begin
            if (i == 700) begin
                reset_n = 0; boot_done = 0;
            end else if (i == 701) reset_n = 1;
            else if (i == 30 || i == 730) boot_done = 1;
            boot_req = $urandom_range(0, 1);
            boot_wren = $urandom_range(0, 1);
            boot_address = rand_addr();
            boot_data_in = $urandom;
            if (!fetch_req || s_fg) begin
                fetch_req = $urandom_range(0, 3) != 0;
                fetch_address = rand_addr();
            end
            if (!data_req || s_dg) begin
                data_req = $urandom_range(0, 3) != 0;
                data_wren = $urandom_range(0, 2) == 0;
                data_address = rand_addr();
                data_wdata = $urandom;
            end
            settle();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
